// File: rtl/regfile_ctrl_if.sv
// Instruction handshake plus register-set read/write bus between decode,
// the sequencing controller and the 4-entry register set.
interface regfile_ctrl_if #(
   parameter int DATA_W = 5,
   parameter int ADDR_W = 2
);
   // instruction handshake from decode
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        op;
   logic [ADDR_W-1:0] dst;
   logic [ADDR_W-1:0] src1;
   logic [ADDR_W-1:0] src2;
   logic [DATA_W-1:0] imm;
   // register-set read ports (a/b are combinational from Ra/Rb)
   logic [ADDR_W-1:0] Ra;
   logic [ADDR_W-1:0] Rb;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   // register-set write port
   logic [ADDR_W-1:0] Wr;
   logic [DATA_W-1:0] Wrd;
   logic              reg_en;
   // completion status
   logic              done;
   logic [DATA_W-1:0] result;
   logic              zero;
   logic              carry;

   // controller side
   modport master (
      input  in_valid, op, dst, src1, src2, imm, a, b,
      output in_ready, Ra, Rb, Wr, Wrd, reg_en, done, result, zero, carry
   );

   // decode / register-set side
   modport slave (
      output in_valid, op, dst, src1, src2, imm, a, b,
      input  in_ready, Ra, Rb, Wr, Wrd, reg_en, done, result, zero, carry
   );
endinterface

// File: rtl/regfile_ctrl.sv
// Sequencing controller for the register set: accepts one instruction,
// reads two operands, runs a small ALU and writes the result back.
// Fixed IDLE -> READ -> EXEC -> WRITE cycle, 4 clocks per instruction.
module regfile_ctrl #(
   parameter int DATA_W = 5,
   parameter int ADDR_W = 2
) (
   input  logic           clk,
   input  logic           rst,
   regfile_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_LDI  = 3'b100,
      OP_MOV  = 3'b101,
      OP_NOP0 = 3'b110,
      OP_NOP1 = 3'b111
   } op_t;

   state_t            state_q, state_d;
   op_t               op_q;
   logic [ADDR_W-1:0] dst_q, src1_q, src2_q, wr_q;
   logic [DATA_W-1:0] imm_q, a_q, b_q, result_q, wrd_q;
   logic              zero_q, carry_q;
   // low through reset and the first edge after it, so in_ready stays low until then
   logic              armed_q;

   logic              in_ready, reg_en, done, accept;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry, alu_flags;

   // State register; reset returns to IDLE at once, dropping any in-flight instruction
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic plus the handshake and write strobes decoded from state
   always_comb begin
      // NOTE: every output gets a default first, so no branch can leave one unassigned (no latch).
      state_d  = state_q;
      in_ready = 1'b0;
      reg_en   = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = armed_q;
            if (armed_q && bus.in_valid) state_d = READ;
         end
         READ:  state_d = EXEC;
         EXEC:  state_d = WRITE;
         WRITE: begin
            reg_en  = (op_q != OP_NOP0) && (op_q != OP_NOP1);
            done    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   assign accept = in_ready & bus.in_valid;

   // ALU on the captured operands; NOP/LDI/MOV leave the flags alone
   always_comb begin
      sum       = {1'b0, a_q} + {1'b0, b_q};
      alu_res   = result_q;
      alu_carry = carry_q;
      alu_flags = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res   = sum[DATA_W-1:0];
            alu_carry = sum[DATA_W];
            alu_flags = 1'b1;
         end
         OP_SUB: begin
            alu_res   = a_q - b_q;
            alu_carry = (a_q < b_q);
            alu_flags = 1'b1;
         end
         OP_AND: begin
            alu_res   = a_q & b_q;
            alu_carry = 1'b0;
            alu_flags = 1'b1;
         end
         OP_OR: begin
            alu_res   = a_q | b_q;
            alu_carry = 1'b0;
            alu_flags = 1'b1;
         end
         OP_LDI:  alu_res = imm_q;
         OP_MOV:  alu_res = a_q;
         default: ;
      endcase
   end

   // Instruction latch, operand capture, result/flag and write-port registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed_q  <= 1'b0;
         op_q     <= OP_ADD;
         dst_q    <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         wr_q     <= '0;
         wrd_q    <= '0;
      end else begin
         armed_q <= 1'b1;
         if (accept) begin
            op_q   <= op_t'(bus.op);
            dst_q  <= bus.dst;
            src1_q <= bus.src1;
            src2_q <= bus.src2;
            imm_q  <= bus.imm;
         end
         if (state_q == READ) begin
            a_q <= bus.a;
            b_q <= bus.b;
         end
         if (state_q == EXEC) begin
            // Wr/Wrd are loaded here so they are valid for all of WRITE and hold afterwards
            result_q <= alu_res;
            wrd_q    <= alu_res;
            wr_q     <= dst_q;
            if (alu_flags) begin
               zero_q  <= (alu_res == '0);
               carry_q <= alu_carry;
            end
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.Ra       = src1_q;
   assign bus.Rb       = src2_q;
   assign bus.Wr       = wr_q;
   assign bus.Wrd      = wrd_q;
   assign bus.reg_en   = reg_en;
   assign bus.done     = done;
   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.carry    = carry_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: a behavioural 4-entry register set sits on
// the slave side of the bus; expected values are hand-computed constants.
module tb_regfile_ctrl;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] AND = 3'b010;
   localparam logic [2:0] OR  = 3'b011;
   localparam logic [2:0] LDI = 3'b100;
   localparam logic [2:0] MOV = 3'b101;
   localparam logic [2:0] NOP = 3'b110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   n_writes = 0;
   logic [4:0] rf [4];

   regfile_ctrl_if #(.DATA_W(5), .ADDR_W(2)) bus ();

   regfile_ctrl #(.DATA_W(5), .ADDR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // behavioural register set: combinational reads, write on rising edge
   assign bus.a = rf[bus.Ra];
   assign bus.b = rf[bus.Rb];

   always @(posedge clk) begin
      if (bus.reg_en) begin
         rf[bus.Wr] <= bus.Wrd;
         n_writes++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one instruction and check it at each stage; returns the accept time.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [4:0] imm,
                         input logic exp_en, input logic [4:0] exp_wrd, output time t_acc);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.op       = op;
      bus.dst      = dst;
      bus.src1     = s1;
      bus.src2     = s2;
      bus.imm      = imm;
      bus.in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1 bus.in_valid = 1'b0;
      @(negedge clk);   // READ
      check({tag, " busy"}, {29'd0, bus.in_ready, bus.done, bus.reg_en}, 32'd0);
      check({tag, " Ra/Rb"}, {28'd0, bus.Ra, bus.Rb}, {28'd0, s1, s2});
      @(negedge clk);   // EXEC
      check({tag, " exec"}, {30'd0, bus.done, bus.reg_en}, 32'd0);
      @(negedge clk);   // WRITE
      check({tag, " done"}, 32'(bus.done), 32'd1);
      check({tag, " reg_en"}, 32'(bus.reg_en), 32'(exp_en));
      check({tag, " Wr"}, 32'(bus.Wr), 32'(dst));
      check({tag, " Wrd"}, 32'(bus.Wrd), 32'(exp_wrd));
      @(posedge clk);
      #1;
      check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
      if (exp_en) check({tag, " rf"}, 32'(rf[dst]), 32'(exp_wrd));
   endtask

   initial begin
      time t0, t1;
      int  w0;
      for (int i = 0; i < 4; i++) rf[i] = 5'd0;
      bus.in_valid = 1'b0;
      bus.op       = 3'd0;
      bus.dst      = 2'd0;
      bus.src1     = 2'd0;
      bus.src2     = 2'd0;
      bus.imm      = 5'd0;

      // reset state
      #3;
      check("reset in_ready", 32'(bus.in_ready), 32'd0);
      check("reset outs", {bus.reg_en, bus.done, bus.zero, bus.carry, bus.result,
                           bus.Ra, bus.Rb, bus.Wr, bus.Wrd}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check("release in_ready low", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1 check("release in_ready high", 32'(bus.in_ready), 32'd1);

      // back-to-back loads, 4 cycles apart
      run_op("ldi r0=7", LDI, 2'd0, 2'd0, 2'd0, 5'd7, 1'b1, 5'd7, t0);
      run_op("ldi r1=6", LDI, 2'd1, 2'd0, 2'd0, 5'd6, 1'b1, 5'd6, t1);
      check("accept spacing", 32'(t1 - t0), 32'd40);

      // ADD, MOV and readback through Ra
      run_op("add r2", ADD, 2'd2, 2'd0, 2'd1, 5'd0, 1'b1, 5'd13, t0);
      check("add flags", {30'd0, bus.zero, bus.carry}, 32'd0);
      run_op("mov r3", MOV, 2'd3, 2'd2, 2'd0, 5'd0, 1'b1, 5'd13, t0);
      run_op("nop rd r3", NOP, 2'd0, 2'd3, 2'd3, 5'd0, 1'b0, 5'd13, t0);
      check("readback a", 32'(bus.a), 32'd13);

      // overflow and borrow
      run_op("ldi r0=31", LDI, 2'd0, 2'd0, 2'd0, 5'd31, 1'b1, 5'd31, t0);
      run_op("ldi r1=1", LDI, 2'd1, 2'd0, 2'd0, 5'd1, 1'b1, 5'd1, t0);
      run_op("add wrap", ADD, 2'd2, 2'd0, 2'd1, 5'd0, 1'b1, 5'd0, t0);
      check("add wrap flags", {30'd0, bus.zero, bus.carry}, 32'd3);
      run_op("sub borrow", SUB, 2'd3, 2'd1, 2'd0, 5'd0, 1'b1, 5'd2, t0);
      check("sub flags", {30'd0, bus.zero, bus.carry}, 32'd1);

      // in_valid held high with changing fields while busy
      @(negedge clk);
      bus.op = LDI; bus.dst = 2'd1; bus.imm = 5'd9; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.op = LDI; bus.dst = 2'd2; bus.imm = 5'd21;
      @(negedge clk);
      bus.op = ADD; bus.dst = 2'd3; bus.src1 = 2'd0; bus.src2 = 2'd0;
      @(negedge clk);
      bus.op = LDI; bus.dst = 2'd2; bus.imm = 5'd17;
      @(negedge clk);
      check("busy Wr", 32'(bus.Wr), 32'd1);
      check("busy Wrd", 32'(bus.Wrd), 32'd9);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("busy rf1", 32'(rf[1]), 32'd9);
      check("busy rf2", 32'(rf[2]), 32'd0);
      check("busy rf3", 32'(rf[3]), 32'd2);

      // NOP leaves result and flags untouched
      run_op("nop", NOP, 2'd2, 2'd0, 2'd0, 5'd0, 1'b0, 5'd9, t0);
      check("nop flags", {30'd0, bus.zero, bus.carry}, 32'd1);
      check("nop rf2", 32'(rf[2]), 32'd0);

      // dependency chain
      run_op("chain ldi", LDI, 2'd0, 2'd0, 2'd0, 5'd3, 1'b1, 5'd3, t0);
      run_op("chain add1", ADD, 2'd0, 2'd0, 2'd0, 5'd0, 1'b1, 5'd6, t0);
      run_op("chain add2", ADD, 2'd0, 2'd0, 2'd0, 5'd0, 1'b1, 5'd12, t0);

      // logic ops
      run_op("or r1", OR, 2'd1, 2'd0, 2'd1, 5'd0, 1'b1, 5'd13, t0);
      check("or flags", {30'd0, bus.zero, bus.carry}, 32'd0);
      run_op("and r2", AND, 2'd2, 2'd0, 2'd1, 5'd0, 1'b1, 5'd12, t0);
      run_op("and zero", AND, 2'd3, 2'd0, 2'd3, 5'd0, 1'b1, 5'd0, t0);
      check("and zero flags", {30'd0, bus.zero, bus.carry}, 32'd2);

      // reset during EXEC of ADD r2 = r0 + r1 (12 + 13)
      w0 = n_writes;
      @(negedge clk);
      bus.op = ADD; bus.dst = 2'd2; bus.src1 = 2'd0; bus.src2 = 2'd1; bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);   // READ
      @(negedge clk);   // EXEC
      rst = 1'b1;
      #1;
      check("mid rst in_ready", 32'(bus.in_ready), 32'd0);
      check("mid rst outs", {bus.reg_en, bus.done, bus.zero, bus.carry, bus.result,
                             bus.Ra, bus.Rb, bus.Wr, bus.Wrd}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check("mid rst release low", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1 check("mid rst release high", 32'(bus.in_ready), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      check("mid rst no write", 32'(n_writes - w0), 32'd0);
      check("mid rst rf2", 32'(rf[2]), 32'd12);

      // normal operation after reset
      run_op("post rst add", ADD, 2'd2, 2'd0, 2'd1, 5'd0, 1'b1, 5'd25, t0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global time limit so the run always ends
   initial begin
      #50000;
      failures++;
      $display("FAIL timeout: got no finish expected finish before 50000");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
